// File: rtl/ps2_key_encoder_if.sv
// ----------------------------------------------------------------------------
// ps2_key_encoder_if
//   Bundles the PS/2 line inputs and the decoded keyboard outputs of
//   ps2_key_encoder.
//
//   Signals:
//     ps2_clk_in   raw PS/2 clock line (asynchronous to clk)
//     ps2_data_in  raw PS/2 data line (asynchronous to clk)
//     ps2_key      [10] event toggle, [9] pressed, [8] extended, [7:0] code
//     rx_byte      last good received byte
//     rx_valid     one-cycle pulse, rx_byte is new
//     frame_err    one-cycle pulse, a frame was discarded
//     busy         high while a frame is in progress
//     state_dbg    receive FSM state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP)
//
//   Modports:
//     slave   the encoder: consumes the lines, drives the results
//     master  the environment: drives the lines, observes the results
//
//   Handshake: there is no back-pressure. rx_valid and frame_err are single
//   cycle strobes that are never both high; ps2_key is level data whose bit 10
//   flips exactly once per published event.
// ----------------------------------------------------------------------------
interface ps2_key_encoder_if;
    logic        ps2_clk_in;
    logic        ps2_data_in;
    logic [10:0] ps2_key;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        frame_err;
    logic        busy;
    logic [1:0]  state_dbg;

    modport slave (
        input  ps2_clk_in,
        input  ps2_data_in,
        output ps2_key,
        output rx_byte,
        output rx_valid,
        output frame_err,
        output busy,
        output state_dbg
    );

    modport master (
        output ps2_clk_in,
        output ps2_data_in,
        input  ps2_key,
        input  rx_byte,
        input  rx_valid,
        input  frame_err,
        input  busy,
        input  state_dbg
    );
endinterface

// File: rtl/ps2_key_encoder.sv
// ----------------------------------------------------------------------------
// ps2_key_encoder
//   Deserialises device-to-host PS/2 frames, tracks the E0 (extended) and
//   F0 (break) prefixes, and publishes one toggle-flagged ps2_key event per
//   key make or break.
//
//   Ports:
//     clk      system clock
//     reset_n  asynchronous active-low reset
//     bus      ps2_key_encoder_if.slave (lines in, ps2_key/rx_byte/rx_valid/
//              frame_err/busy/state_dbg out)
//
//   Parameters:
//     CLK_FREQ    system clock in MHz (real), sizes the timeout counter
//     FILTER_LEN  consecutive differing samples before the filtered clock flips
//     TIMEOUT_US  longest allowed gap between falling clock edges in a frame
//
//   Optional feature (macro PS2_KEY_PARITY_CHECK_EN):
//     defined   - a frame also needs odd parity over data+parity bit
//     undefined - the parity bit is captured and ignored
// ----------------------------------------------------------------------------
module ps2_key_encoder #(
    parameter real CLK_FREQ   = 96.0,
    parameter int  FILTER_LEN = 8,
    parameter int  TIMEOUT_US = 200
) (
    input  logic              clk,
    input  logic              reset_n,
    ps2_key_encoder_if.slave  bus
);

    localparam int TIMEOUT_CYC = int'(CLK_FREQ * real'(TIMEOUT_US));
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);
    localparam int FW          = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers (preset high: idle bus)
    // ------------------------------------------------------------------
    logic clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= bus.ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= bus.ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Clock filter and falling-edge strobe
    // ------------------------------------------------------------------
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          clk_flt_q, clk_flt_d;
    logic          fe_q, fe_d;

    always_comb begin
        flt_cnt_d = '0;
        clk_flt_d = clk_flt_q;
        fe_d      = 1'b0;
        if (clk_sync_q != clk_flt_q) begin
            // Counter holds the number of differing samples already seen;
            // the current one is the FILTER_LEN-th when it reaches LEN-1.
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                clk_flt_d = clk_sync_q;
                fe_d      = clk_flt_q;  // flip from 1 to 0
            end else begin
                flt_cnt_d = flt_cnt_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flt_cnt_q <= '0;
            clk_flt_q <= 1'b1;
            fe_q      <= 1'b0;
        end else begin
            flt_cnt_q <= flt_cnt_d;
            clk_flt_q <= clk_flt_d;
            fe_q      <= fe_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    state_t       state_q, state_d;
    logic [2:0]   bitcnt_q;
    logic [7:0]   shift_q;
    logic         par_q;
    logic [TW-1:0] tmo_q;

    logic tmo_expire;
    logic start_en, shift_en, par_en, accept, frame_bad, parity_ok;

    assign tmo_expire = (state_q != S_IDLE) && !fe_q &&
                        (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tmo_expire) begin
            state_d = S_IDLE;
        end else if (fe_q) begin
            case (state_q)
                S_IDLE:   if (!data_sync_q) state_d = S_DATA;
                S_DATA:   if (bitcnt_q == 3'd7) state_d = S_PARITY;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

`ifdef PS2_KEY_PARITY_CHECK_EN
    assign parity_ok = ^{shift_q, par_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        start_en  = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        accept    = 1'b0;
        frame_bad = tmo_expire;
        if (fe_q) begin
            case (state_q)
                S_IDLE:   start_en = !data_sync_q;
                S_DATA:   shift_en = 1'b1;
                S_PARITY: par_en   = 1'b1;
                S_STOP: begin
                    accept    = data_sync_q && parity_ok;
                    frame_bad = !(data_sync_q && parity_ok);
                end
                default: ;
            endcase
        end
    end

    // Datapath: bit counter, LSB-first shift register, parity, timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            if (start_en) bitcnt_q <= '0;
            else if (shift_en) bitcnt_q <= bitcnt_q + 3'd1;
            if (shift_en) shift_q <= {data_sync_q, shift_q[7:1]};
            if (par_en) par_q <= data_sync_q;
            if (fe_q || state_q == S_IDLE) tmo_q <= '0;
            else tmo_q <= tmo_q + TW'(1);
        end
    end

    logic [7:0] rx_byte_q;
    logic       rx_valid_q, frame_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= accept;
            frame_err_q <= frame_bad;
            if (accept) rx_byte_q <= shift_q;
        end
    end

    // ------------------------------------------------------------------
    // Scancode decoder
    // ------------------------------------------------------------------
    logic        ext_q, ext_d, rel_q, rel_d;
    logic [2:0]  skip_q, skip_d;
    logic [10:0] key_q, key_d;

    always_comb begin
        ext_d  = ext_q;
        rel_d  = rel_q;
        skip_d = skip_q;
        key_d  = key_q;
        if (rx_valid_q) begin
            if (skip_q != 3'd0) begin
                // Pause/Break sequence: swallow the tail, then report it as
                // one extended make of 0x77.
                skip_d = skip_q - 3'd1;
                if (skip_q == 3'd1) begin
                    key_d = {~key_q[10], 1'b1, 1'b1, 8'h77};
                    ext_d = 1'b0;
                    rel_d = 1'b0;
                end
            end else begin
                case (rx_byte_q)
                    8'hE0: ext_d = 1'b1;
                    8'hF0: rel_d = 1'b1;
                    8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                    8'hE1: begin
                        skip_d = 3'd7;
                        ext_d  = 1'b0;
                        rel_d  = 1'b0;
                    end
                    default: begin
                        key_d = {~key_q[10], ~rel_q, ext_q, rx_byte_q};
                        ext_d = 1'b0;
                        rel_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_q  <= 1'b0;
            rel_q  <= 1'b0;
            skip_q <= '0;
            key_q  <= '0;
        end else begin
            ext_q  <= ext_d;
            rel_q  <= rel_d;
            skip_q <= skip_d;
            key_q  <= key_d;
        end
    end

    assign bus.ps2_key   = key_q;
    assign bus.rx_byte   = rx_byte_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
module tb_ps2_key_encoder;
  localparam real CLK_FREQ    = 96.0;
  localparam int  FILTER_LEN  = 8;
  localparam int  TIMEOUT_US  = 20;
  localparam int  TIMEOUT_CYC = 1920;  // round(96.0 * 20)
  localparam int  HALF        = 16;    // PS/2 half period in system clocks
  localparam int  GAP         = 40;    // idle cycles after each frame
`ifdef PS2_KEY_PARITY_CHECK_EN
  localparam bit  PAR_EN = 1'b1;
`else
  localparam bit  PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ps2_key_encoder_if bus();

  ps2_key_encoder #(
    .CLK_FREQ(CLK_FREQ),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int valid_cnt = 0;
  int err_cnt = 0;
  int evt_cnt = 0;
  longint cyc = 0;
  longint last_valid_cyc = 0;
  logic [10:0] prev_key = '0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      prev_key = bus.ps2_key;
    end else begin
      if (bus.rx_valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
      end
      if (bus.frame_err) err_cnt++;
      if (bus.ps2_key != prev_key) begin
        evt_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_event", {21'd0, bus.ps2_key}, {21'd0, prev_key});
        end else begin
          check("event", {21'd0, bus.ps2_key}, {21'd0, exp_q.pop_front()});
        end
        check("event_latency", int'(cyc - last_valid_cyc), 1);
        prev_key = bus.ps2_key;
      end
    end
  end

  // ---------------- reference model ----------------
  logic        m_ext, m_rel;
  int          m_skip;
  logic [10:0] m_key;
  logic [7:0]  m_rx;

  task automatic model_reset();
    m_ext = 0; m_rel = 0; m_skip = 0; m_key = '0; m_rx = '0;
    exp_q.delete();
  endtask

  task automatic model_emit(input logic pressed, input logic ext, input logic [7:0] code);
    m_key = {~m_key[10], pressed, ext, code};
    exp_q.push_back(m_key);
    m_ext = 0;
    m_rel = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_rx = b;
    if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) model_emit(1'b1, 1'b1, 8'h77);
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
      m_ext = 0;
      m_rel = 0;
    end else if (b == 8'hE1) begin
      m_skip = 7;
      m_ext = 0;
      m_rel = 0;
    end else begin
      model_emit(!m_rel, m_ext, b);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk);
      bus.ps2_data_in = fr[i];
      repeat (HALF) @(posedge clk);
      bus.ps2_clk_in = 1'b0;
      repeat (HALF) @(posedge clk);
      bus.ps2_clk_in = 1'b1;
    end
    @(posedge clk);
    bus.ps2_data_in = 1'b1;
  endtask

  task automatic apply_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    int v0, e0;
    bit ok;
    v0 = valid_cnt;
    e0 = err_cnt;
    ok = !bad_stop && !(PAR_EN && bad_par);
    if (ok) model_byte(b);
    send_bits(b, bad_par, bad_stop, 11);
    repeat (GAP) @(posedge clk);
    @(negedge clk);
    check("rx_valid_count", valid_cnt - v0, ok ? 1 : 0);
    check("frame_err_count", err_cnt - e0, ok ? 0 : 1);
    check("rx_byte", {24'd0, bus.rx_byte}, {24'd0, m_rx});
    check("ps2_key", {21'd0, bus.ps2_key}, {21'd0, m_key});
    check("pending_events", exp_q.size(), 0);
    check("busy_idle", {31'd0, bus.busy}, 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0]  b;
    bit          bad_par;
    bit          bad_stop;
    logic [10:0] exp_key;
    logic [7:0]  exp_rx;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [7:0] b, input bit bp, input bit bs,
                     input logic [10:0] k, input logic [7:0] rx);
    vec_t v;
    v.b = b; v.bad_par = bp; v.bad_stop = bs; v.exp_key = k; v.exp_rx = rx;
    tbl.push_back(v);
  endtask

  initial begin
    int e0;
    bit seen;
    logic [7:0] b;
    int sel;

    bus.ps2_clk_in = 1'b1;
    bus.ps2_data_in = 1'b1;
    model_reset();

    // Make / break / extended / prefix-order / error-persistence / pause
    add(8'h1C, 0, 0, 11'h61C, 8'h1C);
    add(8'hF0, 0, 0, 11'h61C, 8'hF0);
    add(8'h1C, 0, 0, 11'h01C, 8'h1C);
    add(8'hE0, 0, 0, 11'h01C, 8'hE0);
    add(8'h75, 0, 0, 11'h775, 8'h75);
    add(8'hE0, 0, 0, 11'h775, 8'hE0);
    add(8'hF0, 0, 0, 11'h775, 8'hF0);
    add(8'h75, 0, 0, 11'h175, 8'h75);
    add(8'h55, 0, 1, 11'h175, 8'h75);
    add(8'h29, 0, 0, 11'h629, 8'h29);
    add(8'hF0, 0, 0, 11'h629, 8'hF0);
    add(8'hE0, 0, 0, 11'h629, 8'hE0);
    add(8'h6B, 0, 0, 11'h16B, 8'h6B);
    add(8'hE0, 0, 0, 11'h16B, 8'hE0);
    add(8'hE0, 0, 0, 11'h16B, 8'hE0);
    add(8'h74, 0, 0, 11'h774, 8'h74);
    add(8'hF0, 0, 0, 11'h774, 8'hF0);
    add(8'h33, 0, 1, 11'h774, 8'hF0);
    add(8'h5A, 0, 0, 11'h05A, 8'h5A);
    add(8'hE0, 0, 0, 11'h05A, 8'hE0);
    add(8'hAA, 0, 0, 11'h05A, 8'hAA);
    add(8'h12, 0, 0, 11'h612, 8'h12);
    add(8'hE1, 0, 0, 11'h612, 8'hE1);
    add(8'h14, 0, 0, 11'h612, 8'h14);
    add(8'h77, 0, 0, 11'h612, 8'h77);
    add(8'hE1, 0, 0, 11'h612, 8'hE1);
    add(8'hF0, 0, 0, 11'h612, 8'hF0);
    add(8'h14, 0, 0, 11'h612, 8'h14);
    add(8'hF0, 0, 0, 11'h612, 8'hF0);
    add(8'h77, 0, 0, 11'h377, 8'h77);
`ifdef PS2_KEY_PARITY_CHECK_EN
    add(8'h1C, 1, 0, 11'h377, 8'h77);
`else
    add(8'h1C, 1, 0, 11'h61C, 8'h1C);
`endif

    // Reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_key", {21'd0, bus.ps2_key}, 0);
    check("reset_rx_byte", {24'd0, bus.rx_byte}, 0);
    check("reset_strobes", {30'd0, bus.rx_valid, bus.frame_err}, 0);
    check("reset_busy", {31'd0, bus.busy}, 0);
    @(posedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);

    foreach (tbl[i]) begin
      apply_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop);
      check($sformatf("tbl%0d_key", i), {21'd0, bus.ps2_key}, {21'd0, tbl[i].exp_key});
      check($sformatf("tbl%0d_rx", i), {24'd0, bus.rx_byte}, {24'd0, tbl[i].exp_rx});
    end

    // Randomised frames against the model
    for (int n = 0; n < 50; n++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1: b = 8'hE0;
        2, 3: b = 8'hF0;
        4: b = 8'hAA;
        5: b = (($urandom_range(0, 3) == 0) ? 8'hE1 : 8'hFA);
        default: b = 8'($urandom_range(0, 255));
      endcase
      apply_frame(b, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
    end

    // Reset mid-frame
    send_bits(8'h3C, 0, 0, 4);
    @(negedge clk);
    check("midframe_busy", {31'd0, bus.busy}, 1);
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midreset_busy", {31'd0, bus.busy}, 0);
    check("midreset_key", {21'd0, bus.ps2_key}, 0);
    check("midreset_rx", {24'd0, bus.rx_byte}, 0);
    @(posedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    apply_frame(8'h1C, 0, 0);
    check("after_reset_key", {21'd0, bus.ps2_key}, 32'h61C);

    // Timeout: prefix survives, partial byte is dropped
    apply_frame(8'hF0, 0, 0);
    e0 = err_cnt;
    send_bits(8'h5A, 0, 0, 5);
    @(negedge clk);
    check("tmo_busy_before", {31'd0, bus.busy}, 1);
    seen = 0;
    for (int t = 0; t < TIMEOUT_CYC + 200; t++) begin
      @(negedge clk);
      if (err_cnt != e0) begin
        seen = 1;
        break;
      end
    end
    check("tmo_frame_err", {31'd0, seen}, 1);
    @(negedge clk);
    check("tmo_err_count", err_cnt - e0, 1);
    check("tmo_busy_after", {31'd0, bus.busy}, 0);
    apply_frame(8'h16, 0, 0);
    check("tmo_next_key", {21'd0, bus.ps2_key}, 32'h016);

    check("total_events", evt_cnt > 0 ? 1 : 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
